// File: rtl/rle.sv
// rle: run-length encoder over a shared word SRAM; define RLE_BUSY_EN to add the busy output
module rle #(
    parameter int MAX_RUN = 255
) (
    input  logic        clk,
    input  logic        nreset,
`ifdef RLE_BUSY_EN
    output logic        busy,
`endif
    input  logic        start,
    input  logic [31:0] message_addr,
    input  logic [31:0] message_size,
    input  logic [31:0] rle_addr,
    output logic [31:0] rle_size,
    output logic        done,
    output logic        port_A_clk,
    output logic [31:0] port_A_data_in,
    input  logic [31:0] port_A_data_out,
    output logic [15:0] port_A_addr,
    output logic        port_A_we
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, SCAN, WRITE, FLUSH, DONE} state_t;
    localparam logic [7:0] MAX = 8'(MAX_RUN);
    state_t state, state_nx;
    logic        start_q, accept, emit, half;
    logic [31:0] size, idx, word, obuf, flush_word;
    logic [13:0] src_base, dst_base, wcnt;
    logic [7:0]  count, sym, cur;
    logic [15:0] rd_addr, wr_addr;
    logic        unused_bits;

    // where to go once byte index i has been consumed: end of message, end of word, or next lane
    function automatic state_t after(input logic [31:0] i, input logic [31:0] n);
        return i == n ? FLUSH : i[1:0] == 2'b00 ? READ : SCAN;
    endfunction

    assign unused_bits = ^{message_addr[31:16], message_addr[1:0], rle_addr[31:16], rle_addr[1:0]};
    assign port_A_clk  = clk;
    assign accept      = start & ~start_q & (state == IDLE || state == DONE);
    assign cur         = word[{idx[1:0], 3'b000} +: 8];
    assign emit        = count != '0 && (cur != sym || count >= MAX);
    assign rd_addr     = {src_base + idx[15:2], 2'b00};
    assign wr_addr     = {dst_base + wcnt, 2'b00};
    assign flush_word  = half ? {sym, count, obuf[15:0]} : {16'h0, sym, count};

    // state register
    always_ff @(posedge clk) begin
        if (!nreset) state <= IDLE;
        else state <= state_nx;
    end

    // next-state decode; an empty message skips straight to the flush
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = accept ? (message_size == '0 ? FLUSH : READ) : state;
            READ:       state_nx = WAIT;
            WAIT:       state_nx = SCAN;
            SCAN:       state_nx = emit && half ? WRITE : after(idx + 32'd1, size);
            WRITE:      state_nx = after(idx, size);
            FLUSH:      state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // memory port and status outputs; the flush writes only if a run is pending
    always_comb begin
        port_A_we      = state == WRITE || (state == FLUSH && count != '0);
        port_A_addr    = state == READ ? rd_addr : port_A_we ? wr_addr : '0;
        port_A_data_in = state == WRITE ? obuf : port_A_we ? flush_word : '0;
        done           = state == DONE;
`ifdef RLE_BUSY_EN
        busy           = nreset && state != IDLE && state != DONE;
`endif
    end

    // job registers, byte scanner and little-endian pair packer
    always_ff @(posedge clk) begin
        if (!nreset) begin
            start_q  <= 1'b0;
            rle_size <= '0;
            size     <= '0;
            idx      <= '0;
            word     <= '0;
            obuf     <= '0;
            src_base <= '0;
            dst_base <= '0;
            wcnt     <= '0;
            count    <= '0;
            sym      <= '0;
            half     <= 1'b0;
        end else begin
            start_q <= start;
            if (accept) begin
                size     <= message_size;
                src_base <= message_addr[15:2];
                dst_base <= rle_addr[15:2];
                idx      <= '0;
                wcnt     <= '0;
                count    <= '0;
                half     <= 1'b0;
                rle_size <= '0;
            end
            if (state == WAIT) word <= port_A_data_out;
            if (state == SCAN) begin
                idx   <= idx + 32'd1;
                sym   <= cur;
                count <= (emit || count == '0) ? 8'd1 : count + 8'd1;
                if (emit) begin
                    half     <= ~half;
                    rle_size <= rle_size + 32'd2;
                    if (half) obuf[31:16] <= {sym, count};
                    else obuf <= {16'h0, sym, count};
                end
            end
            if (state == WRITE) wcnt <= wcnt + 14'd1;
            if (state == FLUSH && port_A_we) rle_size <= rle_size + 32'd2;
        end
    end
endmodule

// File: tb/tb_rle.sv
// tb_rle: directed scoreboard bench for the rle encoder with a word SRAM model
module tb_rle;
    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] message_addr = '0;
    logic [31:0] message_size = '0;
    logic [31:0] rle_addr = '0;
    logic [31:0] rle_size, port_A_data_in, port_A_data_out;
    logic        done, port_A_clk, port_A_we;
    logic [15:0] port_A_addr;
`ifdef RLE_BUSY_EN
    logic        busy;
`endif
    logic        ld_we = 1'b0;
    logic [13:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] mem [0:16383];
    logic [7:0]  msg [0:1023];
    logic [47:0] exp_q [$];
    logic [47:0] act [0:255];
    int          total = 0, bad = 0;
    int          writes = 0, reads = 0, misalign = 0;
    int          exp_size = 0, last_reads = 0;
    logic [15:0] rd_lo = '0, rd_hi = '0;

    always #5 clk = ~clk;

    rle dut (
        .clk(clk),
        .nreset(nreset),
`ifdef RLE_BUSY_EN
        .busy(busy),
`endif
        .start(start),
        .message_addr(message_addr),
        .message_size(message_size),
        .rle_addr(rle_addr),
        .rle_size(rle_size),
        .done(done),
        .port_A_clk(port_A_clk),
        .port_A_data_in(port_A_data_in),
        .port_A_data_out(port_A_data_out),
        .port_A_addr(port_A_addr),
        .port_A_we(port_A_we)
    );

    // word SRAM with one-cycle registered read; the preload port wins
    always @(posedge port_A_clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
        else if (port_A_we) mem[port_A_addr[15:2]] <= port_A_data_in;
        port_A_data_out <= mem[port_A_addr[15:2]];
    end

    // bus monitor, sampled mid-cycle: records writes and counts reads inside the source window
    always @(negedge clk) begin
        if (port_A_addr[1:0] != 2'b00) misalign++;
        if (port_A_we) begin
            if (writes < 256) act[writes] = {port_A_addr, port_A_data_in};
            writes++;
        end else if (port_A_addr >= rd_lo && port_A_addr < rd_hi) reads++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    // preload message bytes plus one extra word; bytes past the end repeat the last symbol
    task automatic load(input logic [31:0] src, input int size);
        logic [7:0] junk;
        junk = msg[size > 0 ? size - 1 : 0];
        for (int w = 0; w < (size + 3) / 4 + 1; w++) begin
            ld_we   = 1'b1;
            ld_addr = src[15:2] + 14'(w);
            for (int b = 0; b < 4; b++) ld_data[8*b +: 8] = (4*w + b < size) ? msg[4*w + b] : junk;
            tick(1);
        end
        ld_we = 1'b0;
    endtask

    // reference encoder: builds the byte stream, then packs it into expected writes
    task automatic model(input int size, input logic [31:0] dst);
        logic [7:0]  st [$];
        logic [7:0]  s;
        logic [31:0] d;
        int          cnt;
        s   = '0;
        cnt = 0;
        for (int i = 0; i < size; i++) begin
            if (cnt > 0 && msg[i] == s && cnt < 255) cnt++;
            else begin
                if (cnt > 0) begin st.push_back(8'(cnt)); st.push_back(s); end
                s   = msg[i];
                cnt = 1;
            end
        end
        if (cnt > 0) begin st.push_back(8'(cnt)); st.push_back(s); end
        exp_size = st.size();
        for (int w = 0; 4*w < st.size(); w++) begin
            d = '0;
            for (int b = 0; b < 4; b++) if (4*w + b < st.size()) d[8*b +: 8] = st[4*w + b];
            exp_q.push_back({dst[15:0] + 16'(4*w), d});
        end
    endtask

    task automatic run(input string tag, input logic [31:0] src, input int size, input logic [31:0] dst, input int hold);
        int w0, r0, n;
        model(size, dst);
        rd_lo        = src[15:0];
        rd_hi        = src[15:0] + 16'(4 * ((size + 3) / 4 + 1));
        w0           = writes;
        r0           = reads;
        message_addr = src;
        message_size = size;
        rle_addr     = dst;
        start        = 1'b1;
        tick(hold);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20000) begin tick(1); n++; end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_size"}, rle_size, exp_size);
        chk({tag, "_nwr"}, writes - w0, exp_q.size());
        for (int i = w0; i < writes && i < 256; i++)
            chk({tag, "_wr"}, act[i], exp_q.size() > 0 ? exp_q.pop_front() : 48'hx);
        exp_q.delete();
        last_reads = reads - r0;
    endtask

    initial begin
        int ws, r0;
        tick(3);
        chk("rst_done", done, 0);
        chk("rst_size", rle_size, 0);
        chk("rst_we", port_A_we, 0);
        chk("rst_addr", port_A_addr, 0);
        chk("rst_din", port_A_data_in, 0);
        nreset = 1'b1;
        tick(2);
        chk("idle_done", done, 0);

        for (int i = 0; i < 39; i++) msg[i] = 8'h10 + 8'(i);
        load(32'h0, 39);
        run("distinct", 32'h0, 39, 32'hC8, 2);
        chk("distinct_w50", mem[50], 32'h11011001);
        chk("distinct_w69", mem[69], 32'h00003601);
        ws = writes;
        tick(5);
        chk("distinct_hold", done, 1);
        chk("distinct_onejob", writes, ws);

        for (int i = 0; i < 300; i++) msg[i] = 8'hAA;
        load(32'h400, 300);
        run("aa", 32'h400, 300, 32'h800, 1);
        chk("aa_word", mem[512], 32'hAA2DAAFF);
        chk("aa_reads", last_reads, 75);

        msg[0] = 8'h11; msg[1] = 8'h11; msg[2] = 8'h11; msg[3] = 8'h22; msg[4] = 8'h22;
        load(32'h1000, 5);
        run("five", 32'h1000, 5, 32'h1400, 1);
        chk("five_word", mem[32'h500], 32'h22021103);
        chk("five_reads", last_reads, 2);

        ws           = writes;
        rd_lo        = 16'h3000;
        rd_hi        = 16'h3004;
        r0           = reads;
        message_addr = 32'h3000;
        message_size = 32'd0;
        rle_addr     = 32'h3400;
        start        = 1'b1;
        tick(1);
        start = 1'b0;
        chk("zero_done1", done, 0);
        tick(1);
        chk("zero_done2", done, 1);
        chk("zero_size", rle_size, 0);
        chk("zero_nwr", writes - ws, 0);
        chk("zero_reads", reads - r0, 0);

        message_addr = 32'h400;
        message_size = 32'd300;
        rle_addr     = 32'h800;
        start        = 1'b1;
        tick(1);
        start = 1'b0;
        tick(20);
        chk("abort_busy", done, 0);
        nreset = 1'b0;
        tick(1);
        chk("abort_done", done, 0);
        chk("abort_size", rle_size, 0);
        chk("abort_we", port_A_we, 0);
        chk("abort_addr", port_A_addr, 0);
        tick(1);
        nreset = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) msg[i] = 8'h77;
        load(32'h2000, 4);
        run("four", 32'h2000, 4, 32'h2400, 1);
        chk("four_word", mem[32'h900] & 32'hFFFF00FF, 32'h00000004);

        msg[0] = 8'h11; msg[1] = 8'h11; msg[2] = 8'h11; msg[3] = 8'h22; msg[4] = 8'h22;
        run("again", 32'h1000, 5, 32'h1800, 1);
        chk("again_word", mem[32'h600], 32'h22021103);
        chk("align", misalign, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
